pad_output_sequencer: RTL and testbench
=======================================

// Module: pad_output_sequencer
// PURPOSE
//  Sits directly upstream of an output pad cell and drives its pad_in_i, pad_oe_i and
//  pad_attributes_i inputs. Sequences output-enable so data is stable for SETUP_CYC cycles
//  before the pad drives, and held for HOLD_CYC cycles after it releases. Attribute
//  (drive/slew) changes are applied only while the pad is not driving, followed by a settle gap.
// PARAMETERS
//  PADATTR    16  width of the pad attribute bus
//  SETUP_CYC  2   cycles data is stable with OE low before OE rises (0 = no pre-drive)
//  HOLD_CYC   1   cycles data is frozen after OE falls (0 = no hold)
//  SETTLE_CYC 2   cycles OE is forced low after an attribute update (0 = no settle)
//  RST_ATTR   '0  pad_attributes_o value after reset
// PORTS
//  clk_i            in   1        clock
//  rst_i            in   1        synchronous reset, active-high
//  data_i           in   1        output value requested by the peripheral or GPIO
//  oe_req_i         in   1        output-enable request (level)
//  attr_i           in   PADATTR  new pad attributes
//  attr_valid_i     in   1        attr_i valid; transfer occurs when attr_valid_i & attr_ready_o
//  attr_ready_o     out  1        sequencer can accept attributes (1 only in IDLE)
//  pad_in_o         out  1        to the pad cell's pad_in_i
//  pad_oe_o         out  1        to the pad cell's pad_oe_i
//  pad_attributes_o out  PADATTR  to the pad cell's pad_attributes_i
//  busy_o           out  1        1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (sync, rst_i sampled high), all values next edge:
//    state=IDLE, counter=0, pad_in_o=0, pad_oe_o=0, pad_attributes_o=RST_ATTR, busy_o=0.
//    Reset overrides every state, including mid-SETUP, mid-DRIVE, mid-RELEASE and mid-ATTR.
//    pad_oe_o is 0 on the first edge rst_i is high.
//  - pad_in_o, pad_oe_o and pad_attributes_o are registered. attr_ready_o = (state==IDLE);
//    it is derived from the state register only, with no combinational path from inputs.
//  - Counter width is $clog2(max(SETUP_CYC,HOLD_CYC,SETTLE_CYC)+1). Counting saturates and
//    never wraps.
//  - IDLE: pad_oe_o=0; pad_in_o <= data_i every edge (1-cycle latency).
//    On an edge with attr_valid_i=1: accept, pad_attributes_o <= attr_i.
//      Go to ATTR, or stay in IDLE if SETTLE_CYC=0.
//    Else if oe_req_i=1: go to SETUP, or to DRIVE with pad_oe_o<=1 if SETUP_CYC=0.
//    If attribute and OE requests arrive on the same edge, the attribute wins.
//      oe_req_i is re-evaluated only after the block returns to IDLE.
//  - SETUP: pad_oe_o=0; pad_in_o keeps tracking data_i.
//    The counter counts edges with oe_req_i=1. After SETUP_CYC such edges in IDLE+SETUP,
//      go to DRIVE with pad_oe_o<=1.
//      Net effect: pad_oe_o is first 1 after the (SETUP_CYC+1)-th consecutive edge with oe_req_i=1.
//    If oe_req_i=0 on any SETUP edge: abort to IDLE. pad_oe_o stays 0 and HOLD is not applied.
//  - DRIVE: pad_oe_o=1; pad_in_o <= data_i every edge; attr_ready_o=0.
//    On an edge with oe_req_i=0: pad_oe_o<=0 on that same edge, and pad_in_o freezes
//      (it is not updated on that edge).
//    Then go to RELEASE, or to IDLE if HOLD_CYC=0.
//  - RELEASE: pad_oe_o=0; pad_in_o frozen for HOLD_CYC edges; oe_req_i and attr_valid_i ignored.
//    Then go to IDLE, where tracking resumes on the next edge.
//  - ATTR: pad_oe_o=0; pad_in_o tracks data_i; lasts SETTLE_CYC edges; then go to IDLE.
//    oe_req_i held high during ATTR starts SETUP only after the return to IDLE.
//  - pad_oe_o never glitches. It changes only on IDLE/SETUP->DRIVE and on DRIVE->RELEASE/IDLE
//    transitions.
// TESTING
//  1 Reset: drive rst_i=1 for 2 cycles from DRIVE with data_i=1 -> next edge pad_oe_o=0,
//    pad_in_o=0, pad_attributes_o=RST_ATTR, busy_o=0.
//  2 Enable, defaults: data_i=1, oe_req_i rises at edge 0 -> pad_in_o=1 from edge 0;
//    pad_oe_o=0 at edges 0-1 and =1 after edge 2.
//  3 Release: in DRIVE with data_i=1, drop oe_req_i and data_i=0 at edge N -> pad_oe_o=0
//    after N; pad_in_o stays 1 after N and N+1; pad_in_o=0 after N+2.
//  4 Abort: oe_req_i high for a single edge only -> pad_oe_o never asserts; back in IDLE
//    (busy_o=0) after the second edge.
//  5 Attribute collision: in IDLE, attr_valid_i=1, attr_i=16'hA5A5 and oe_req_i=1 on the same
//    edge -> pad_attributes_o=16'hA5A5; ATTR for 2 cycles with attr_ready_o=0; pad_oe_o rises
//    SETUP_CYC+1 edges after re-entering IDLE.
//  6 Blocked attribute: attr_valid_i=1 held throughout DRIVE -> attr_ready_o=0 and
//    pad_attributes_o unchanged; the update is accepted on the first IDLE edge after RELEASE.

Source files
------------

// File: rtl/pad_output_sequencer.sv
// Output-enable sequencer for a pad cell: pre-drive setup, post-release hold,
// and attribute updates applied only while the pad is released.
module pad_output_sequencer #(
    parameter int                 PADATTR    = 16,
    parameter int                 SETUP_CYC  = 2,
    parameter int                 HOLD_CYC   = 1,
    parameter int                 SETTLE_CYC = 2,
    parameter logic [PADATTR-1:0] RST_ATTR   = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               data_i,
    input  logic               oe_req_i,
    input  logic [PADATTR-1:0] attr_i,
    input  logic               attr_valid_i,
    output logic               attr_ready_o,
    output logic               pad_in_o,
    output logic               pad_oe_o,
    output logic [PADATTR-1:0] pad_attributes_o,
    output logic               busy_o
);
    localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int MAX_CYC = (MAX_SH > SETTLE_CYC) ? MAX_SH : SETTLE_CYC;
    localparam int CW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_L     = CW'(SETUP_CYC);
    localparam logic [CW-1:0] HOLD_LAST   = (HOLD_CYC > 0) ? CW'(HOLD_CYC - 1) : '0;
    localparam logic [CW-1:0] SETTLE_LAST = (SETTLE_CYC > 0) ? CW'(SETTLE_CYC - 1) : '0;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_DRIVE   = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_ATTR    = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc      = (&cnt) ? cnt : cnt + CW'(1);
    assign attr_ready_o = (state == S_IDLE);
    assign busy_o       = (state != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= S_IDLE;
            cnt              <= '0;
            pad_in_o         <= 1'b0;
            pad_oe_o         <= 1'b0;
            pad_attributes_o <= RST_ATTR;
        end else begin
            case (state)
                S_IDLE: begin
                    pad_in_o <= data_i;
                    cnt      <= '0;
                    // Attribute update takes priority over a simultaneous OE request.
                    if (attr_valid_i) begin
                        pad_attributes_o <= attr_i;
                        if (SETTLE_CYC > 0) state <= S_ATTR;
                    end else if (oe_req_i) begin
                        if (SETUP_CYC == 0) begin
                            state    <= S_DRIVE;
                            pad_oe_o <= 1'b1;
                        end else begin
                            state <= S_SETUP;
                            cnt   <= CW'(1);
                        end
                    end
                end
                S_SETUP: begin
                    pad_in_o <= data_i;
                    if (!oe_req_i) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt >= SETUP_L) begin
                        state    <= S_DRIVE;
                        pad_oe_o <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_DRIVE: begin
                    // On release, pad_in_o keeps its last driven value.
                    if (oe_req_i) begin
                        pad_in_o <= data_i;
                    end else begin
                        pad_oe_o <= 1'b0;
                        cnt      <= '0;
                        state    <= (HOLD_CYC > 0) ? S_RELEASE : S_IDLE;
                    end
                end
                S_RELEASE: begin
                    if (cnt >= HOLD_LAST) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_ATTR: begin
                    pad_in_o <= data_i;
                    if (cnt >= SETTLE_LAST) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    cnt      <= '0;
                    pad_oe_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pad_output_sequencer.sv
// Directed and randomized checks of pad_output_sequencer against a phase-level model.
module tb_pad_output_sequencer;
    localparam int          PADATTR    = 16;
    localparam int          SETUP_CYC  = 2;
    localparam int          HOLD_CYC   = 1;
    localparam int          SETTLE_CYC = 2;
    localparam logic [15:0] RST_ATTR   = 16'h0000;

    localparam int M_IDLE = 0, M_SETUP = 1, M_DRIVE = 2, M_REL = 3, M_ATTR = 4;

    logic        clk = 1'b0;
    logic        rst, data, oe_req, attr_valid;
    logic [15:0] attr;
    logic        attr_ready, pad_in, pad_oe, busy;
    logic [15:0] pad_attr;

    int          n_checks = 0;
    int          n_fail   = 0;

    // model state: phase, consecutive-request streak, edges left in a timed phase
    int          md = M_IDLE;
    int          streak = 0;
    int          left = 0;
    logic        m_in = 1'b0, m_oe = 1'b0;
    logic [15:0] m_attr = RST_ATTR;

    pad_output_sequencer #(
        .PADATTR(PADATTR), .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC),
        .SETTLE_CYC(SETTLE_CYC), .RST_ATTR(RST_ATTR)
    ) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .oe_req_i(oe_req),
        .attr_i(attr), .attr_valid_i(attr_valid), .attr_ready_o(attr_ready),
        .pad_in_o(pad_in), .pad_oe_o(pad_oe), .pad_attributes_o(pad_attr),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        if (rst) begin
            md = M_IDLE; m_in = 1'b0; m_oe = 1'b0; m_attr = RST_ATTR;
        end else begin
            case (md)
                M_IDLE: begin
                    m_in = data;
                    if (attr_valid) begin
                        m_attr = attr;
                        if (SETTLE_CYC > 0) begin md = M_ATTR; left = SETTLE_CYC; end
                    end else if (oe_req) begin
                        streak = 1;
                        if (SETUP_CYC == 0) begin md = M_DRIVE; m_oe = 1'b1; end
                        else md = M_SETUP;
                    end
                end
                M_SETUP: begin
                    m_in = data;
                    if (!oe_req) md = M_IDLE;
                    else begin
                        streak++;
                        if (streak == SETUP_CYC + 1) begin md = M_DRIVE; m_oe = 1'b1; end
                    end
                end
                M_DRIVE: begin
                    if (oe_req) m_in = data;
                    else begin
                        m_oe = 1'b0;
                        if (HOLD_CYC > 0) begin md = M_REL; left = HOLD_CYC; end
                        else md = M_IDLE;
                    end
                end
                M_REL: begin
                    left--;
                    if (left == 0) md = M_IDLE;
                end
                default: begin
                    m_in = data;
                    left--;
                    if (left == 0) md = M_IDLE;
                end
            endcase
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; data = 1'b1; oe_req = 1'b1; attr_valid = 1'b0; attr = 16'hFFFF;
        step(); step();
        rst = 1'b0; oe_req = 1'b0; data = 1'b0;
        n_checks++; if (pad_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got=%b exp=0", pad_oe); end
        n_checks++; if (pad_in !== 1'b0) begin n_fail++; $display("FAIL reset_in got=%b exp=0", pad_in); end
        n_checks++; if (pad_attr !== RST_ATTR) begin n_fail++; $display("FAIL reset_attr got=%h exp=%h", pad_attr, RST_ATTR); end
        n_checks++; if (busy !== 1'b0 || attr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_busy busy=%b ready=%b exp=0/1", busy, attr_ready); end
    endtask

    task automatic test_enable();
        data = 1'b1; oe_req = 1'b1;
        step();
        n_checks++; if (pad_in !== 1'b1 || pad_oe !== 1'b0) begin n_fail++; $display("FAIL enable_e0 in=%b oe=%b exp=1/0", pad_in, pad_oe); end
        step();
        n_checks++; if (pad_oe !== 1'b0) begin n_fail++; $display("FAIL enable_e1 oe=%b exp=0", pad_oe); end
        step();
        n_checks++; if (pad_oe !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL enable_e2 oe=%b busy=%b exp=1/1", pad_oe, busy); end
    endtask

    task automatic test_release();
        step();
        oe_req = 1'b0; data = 1'b0;
        step();
        n_checks++; if (pad_oe !== 1'b0 || pad_in !== 1'b1) begin n_fail++; $display("FAIL release_n oe=%b in=%b exp=0/1", pad_oe, pad_in); end
        step();
        n_checks++; if (pad_in !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL release_n1 in=%b busy=%b exp=1/0", pad_in, busy); end
        step();
        n_checks++; if (pad_in !== 1'b0) begin n_fail++; $display("FAIL release_n2 in=%b exp=0", pad_in); end
    endtask

    task automatic test_abort();
        oe_req = 1'b1; data = 1'b1;
        step();
        n_checks++; if (pad_oe !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_e0 oe=%b busy=%b exp=0/1", pad_oe, busy); end
        oe_req = 1'b0;
        step();
        n_checks++; if (pad_oe !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_e1 oe=%b busy=%b exp=0/0", pad_oe, busy); end
        step();
        n_checks++; if (pad_oe !== 1'b0) begin n_fail++; $display("FAIL abort_e2 oe=%b exp=0", pad_oe); end
    endtask

    task automatic test_attr_collision();
        attr_valid = 1'b1; attr = 16'hA5A5; oe_req = 1'b1;
        step();
        attr_valid = 1'b0;
        n_checks++; if (pad_attr !== 16'hA5A5) begin n_fail++; $display("FAIL collide_attr got=%h exp=a5a5", pad_attr); end
        n_checks++; if (attr_ready !== 1'b0 || pad_oe !== 1'b0) begin n_fail++; $display("FAIL collide_a0 ready=%b oe=%b exp=0/0", attr_ready, pad_oe); end
        step();
        n_checks++; if (attr_ready !== 1'b0) begin n_fail++; $display("FAIL collide_a1 ready=%b exp=0", attr_ready); end
        step();
        n_checks++; if (attr_ready !== 1'b1 || pad_oe !== 1'b0) begin n_fail++; $display("FAIL collide_idle ready=%b oe=%b exp=1/0", attr_ready, pad_oe); end
        for (int i = 0; i < SETUP_CYC; i++) begin
            step();
            n_checks++; if (pad_oe !== 1'b0) begin n_fail++; $display("FAIL collide_setup%0d oe=%b exp=0", i, pad_oe); end
        end
        step();
        n_checks++; if (pad_oe !== 1'b1) begin n_fail++; $display("FAIL collide_drive oe=%b exp=1", pad_oe); end
        oe_req = 1'b0;
        step(); step();
    endtask

    task automatic test_blocked_attr();
        oe_req = 1'b1;
        step(); step(); step();
        attr_valid = 1'b1; attr = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (attr_ready !== 1'b0 || pad_attr !== 16'hA5A5 || pad_oe !== 1'b1) begin
                n_fail++; $display("FAIL blocked_drive%0d ready=%b attr=%h oe=%b exp=0/a5a5/1", i, attr_ready, pad_attr, pad_oe); end
        end
        oe_req = 1'b0;
        step();
        n_checks++; if (attr_ready !== 1'b0 || pad_attr !== 16'hA5A5) begin n_fail++; $display("FAIL blocked_rel ready=%b attr=%h exp=0/a5a5", attr_ready, pad_attr); end
        step();
        n_checks++; if (attr_ready !== 1'b1 || pad_attr !== 16'hA5A5) begin n_fail++; $display("FAIL blocked_idle ready=%b attr=%h exp=1/a5a5", attr_ready, pad_attr); end
        step();
        n_checks++; if (pad_attr !== 16'h1234 || busy !== 1'b1) begin n_fail++; $display("FAIL blocked_accept attr=%h busy=%b exp=1234/1", pad_attr, busy); end
        attr_valid = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_from_drive();
        oe_req = 1'b1; data = 1'b1;
        step(); step(); step();
        n_checks++; if (pad_oe !== 1'b1) begin n_fail++; $display("FAIL rstdrv_pre oe=%b exp=1", pad_oe); end
        rst = 1'b1;
        step();
        n_checks++; if (pad_oe !== 1'b0 || pad_in !== 1'b0) begin n_fail++; $display("FAIL rstdrv_first oe=%b in=%b exp=0/0", pad_oe, pad_in); end
        step();
        rst = 1'b0; oe_req = 1'b0;
        n_checks++; if (pad_attr !== RST_ATTR || busy !== 1'b0) begin n_fail++; $display("FAIL rstdrv_state attr=%h busy=%b exp=%h/0", pad_attr, busy, RST_ATTR); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 80) == 0);
            data       = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 4) == 0) oe_req = ~oe_req;
            attr_valid = ($urandom_range(0, 7) == 0);
            attr       = 16'($urandom);
            step();
            n_checks++; if (pad_oe !== m_oe) begin n_fail++; $display("FAIL rnd%0d_oe got=%b exp=%b", i, pad_oe, m_oe); end
            n_checks++; if (pad_in !== m_in) begin n_fail++; $display("FAIL rnd%0d_in got=%b exp=%b", i, pad_in, m_in); end
            n_checks++; if (pad_attr !== m_attr) begin n_fail++; $display("FAIL rnd%0d_attr got=%h exp=%h", i, pad_attr, m_attr); end
            n_checks++; if (busy !== (md != M_IDLE) || attr_ready !== (md == M_IDLE)) begin
                n_fail++; $display("FAIL rnd%0d_busy busy=%b ready=%b exp_idle=%0d", i, busy, attr_ready, md == M_IDLE); end
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_release();
        test_abort();
        test_attr_collision();
        test_blocked_attr();
        test_reset_from_drive();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
